// File: rtl/clock_sequencer.sv
// CPU clock sequencer: free-run divider, debounced single-step and HLT halt.
// Define CLOCK_HALT_RESUME_EN to let a step press leave HALTED.
module clock_sequencer #(
   parameter int                   DIV_WIDTH       = 24,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV     = '0,
   parameter int                   DEBOUNCE_CYCLES = 16
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 button,
   input  logic                 halt,
   input  logic                 div_load,
   input  logic [DIV_WIDTH-1:0] div_value,
   output logic                 cpu_clk,
   output logic                 cpu_clk_en,
   output logic                 halted
);
   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {LOW, HIGH, HALTED} state_t;

   state_t               state, state_next;
   logic                 sync_0, sync_1, db_level, press;
   logic [DB_W-1:0]      db_count;
   logic [DIV_WIDTH-1:0] count, count_next, div_reg;
   logic                 halt_q, halt_q_next, clk_en_next, phase_end;

   // Button path: two-flop synchroniser, then the level only follows after a
   // full run of mismatching samples; press marks the debounced rising edge.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync_0   <= 1'b0;
         sync_1   <= 1'b0;
         db_level <= 1'b0;
         db_count <= '0;
         press    <= 1'b0;
      end else begin
         sync_0 <= button;
         sync_1 <= sync_0;
         press  <= 1'b0;
         if (sync_1 == db_level) begin
            db_count <= '0;
         end else if (db_count == DB_LAST) begin
            db_level <= sync_1;
            db_count <= '0;
            press    <= sync_1;
         end else begin
            db_count <= db_count + 1'b1;
         end
      end
   end

   assign phase_end = (count >= div_reg);

   always_comb begin
      state_next  = state;
      count_next  = count;
      halt_q_next = halt_q | halt;
      clk_en_next = 1'b0;
      case (state)
         LOW: begin
            if (halt_q || halt) begin
               state_next = HALTED;
               count_next = '0;
            end else if (!mode) begin
               if (phase_end) begin
                  state_next  = HIGH;
                  count_next  = '0;
                  clk_en_next = 1'b1;
               end else begin
                  count_next = count + 1'b1;
               end
            end else begin
               count_next = '0;
               if (press) begin
                  state_next  = HIGH;
                  clk_en_next = 1'b1;
               end
            end
         end
         // The high phase always runs to completion; presses here are dropped.
         HIGH: begin
            if (phase_end) begin
               state_next = LOW;
               count_next = '0;
            end else begin
               count_next = count + 1'b1;
            end
         end
         HALTED: begin
            count_next = '0;
`ifdef CLOCK_HALT_RESUME_EN
            if (press && !halt) begin
               state_next  = LOW;
               halt_q_next = 1'b0;
            end
`endif
         end
         default: begin
            state_next = LOW;
            count_next = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change with the state.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= LOW;
         count      <= '0;
         div_reg    <= DEFAULT_DIV;
         halt_q     <= 1'b0;
         cpu_clk    <= 1'b0;
         cpu_clk_en <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         halt_q     <= halt_q_next;
         if (div_load) div_reg <= div_value;
         cpu_clk    <= (state_next == HIGH);
         cpu_clk_en <= clk_en_next;
         halted     <= (state_next == HALTED);
      end
   end
endmodule

// File: tb/tb_clock_sequencer.sv
// Scoreboard bench for clock_sequencer: directed test-plan scenarios plus
// randomized traffic, all checked against a behavioural model.
module tb_clock_sequencer;
   localparam int DB      = 8;
   localparam int DEF_DIV = 2;

   logic        sys_clk, rst, mode, button, halt, div_load;
   logic [23:0] div_value;
   logic        cpu_clk, cpu_clk_en, halted;

   clock_sequencer #(
      .DIV_WIDTH(24), .DEFAULT_DIV(24'(DEF_DIV)), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .mode(mode), .button(button), .halt(halt),
      .div_load(div_load), .div_value(div_value),
      .cpu_clk(cpu_clk), .cpu_clk_en(cpu_clk_en), .halted(halted)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {bit clk; bit halted;} lvl_t;
   lvl_t lvl_q[$];
   int   rise_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   bit   m_valid = 0, m_level, m_halted, m_halt_seen, m_db, m_press;
   int   m_elapsed, m_div;
   bit   m_hist[$];
   bit   m_win[$];

   task automatic check_val(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // Reference model: one call per sys_clk edge using the inputs sampled there.
   task automatic model_edge();
      bit sample, all_diff, press_now, exp_en;
      exp_en = 1'b0;
      if (rst) begin
         m_valid = 1; m_level = 0; m_halted = 0; m_halt_seen = 0;
         m_elapsed = 0; m_div = DEF_DIV; m_db = 0; m_press = 0;
         m_hist = '{1'b0, 1'b0};
         m_win.delete();
      end else if (m_valid) begin
         press_now = m_press;
         m_press = 0;
         m_hist.push_front(button);
         sample = m_hist[2];
         while (m_hist.size() > 3) void'(m_hist.pop_back());
         m_win.push_back(sample);
         if (m_win.size() > DB) void'(m_win.pop_front());
         all_diff = (m_win.size() == DB);
         foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
         if (all_diff) begin
            m_db = sample;
            m_press = sample;
            m_win.delete();
         end
         if (m_halted) begin
`ifdef CLOCK_HALT_RESUME_EN
            if (press_now && !halt) begin
               m_halted = 0; m_halt_seen = 0; m_elapsed = 0;
            end
`endif
         end else if (m_level) begin
            if (m_elapsed >= m_div) begin m_level = 0; m_elapsed = 0; end
            else m_elapsed++;
         end else if (m_halt_seen || halt) begin
            m_halted = 1; m_elapsed = 0;
         end else if (!mode) begin
            if (m_elapsed >= m_div) begin m_level = 1; m_elapsed = 0; exp_en = 1; end
            else m_elapsed++;
         end else begin
            m_elapsed = 0;
            if (press_now) begin m_level = 1; exp_en = 1; end
         end
         m_halt_seen = m_halt_seen | halt;
         if (div_load) m_div = int'(div_value);
      end
      if (m_valid) begin
         lvl_q.push_back('{m_level, m_halted});
         if (exp_en) rise_q.push_back(cyc);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      model_edge();
   endtask

   task automatic apply_stimulus(input bit r, input bit m, input bit b, input bit h,
                                 input bit dl, input int dv);
      rst = r; mode = m; button = b; halt = h; div_load = dl; div_value = 24'(dv);
      tick();
   endtask

   task automatic edges_to_rise(input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if (cpu_clk_en) begin n = i; break; end
      end
   endtask

   task automatic run_idle(input int cycles, output int rises);
      rises = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (cpu_clk_en) rises++;
      end
   endtask

   // Monitor: pops the expected level every cycle and an expected rising edge
   // whenever the DUT strobes cpu_clk_en (or should have).
   task automatic check_output();
      lvl_t e;
      if (lvl_q.size() != 0) begin
         e = lvl_q.pop_front();
         check_val("cpu_clk_level", int'(cpu_clk), int'(e.clk));
         check_val("halted_level", int'(halted), int'(e.halted));
      end
      if (cpu_clk_en) begin
         if (rise_q.size() == 0) check_val("unexpected_rise_cycle", cyc, -1);
         else check_val("rise_cycle", cyc, rise_q.pop_front());
      end else if (rise_q.size() != 0 && rise_q[0] <= cyc) begin
         check_val("missed_rise_cycle", -1, rise_q.pop_front());
      end
   endtask

   always @(negedge sys_clk) if (m_valid) check_output();

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, k, hold;
      bit r_mode, r_btn;
      rst = 1; mode = 0; button = 0; halt = 0; div_load = 0; div_value = '0;
      tick();
      tick();
      check_val("reset_cpu_clk", int'(cpu_clk), 0);
      check_val("reset_cpu_clk_en", int'(cpu_clk_en), 0);
      check_val("reset_halted", int'(halted), 0);

      // Run mode with the default divider: 3 low, 3 high
      rst = 0;
      edges_to_rise(20, n); check_val("run_first_rise", n, 3);
      edges_to_rise(20, n); check_val("run_period_a", n, 6);
      edges_to_rise(20, n); check_val("run_period_b", n, 6);

      // Manual step, div=1, clean press then a short glitch
      rst = 1; tick(); rst = 0;
      mode = 1; div_load = 1; div_value = 24'd1; tick(); div_load = 0;
      button = 1;
      edges_to_rise(60, n); check_val("step_press_latency", n, DB + 3);
      tick(); check_val("step_high_2nd", int'(cpu_clk), 1);
      tick(); check_val("step_low_after", int'(cpu_clk), 0);
      run_idle(20, k); check_val("step_single_pulse", k, 0);
      button = 0; run_idle(20, k);
      button = 1; run_idle(5, n);
      button = 0; run_idle(30, k); check_val("glitch_no_press", n + k, 0);

      // Halt pulsed mid high phase, div=3
      rst = 1; tick(); rst = 0;
      mode = 0; div_load = 1; div_value = 24'd3; tick(); div_load = 0;
      edges_to_rise(40, n);
      tick();
      halt = 1; tick(); halt = 0;
      tick(); check_val("halt_high_completes", int'(cpu_clk), 1);
      tick(); check_val("halt_one_low_clk", int'(cpu_clk), 0);
      check_val("halt_one_low_halted", int'(halted), 0);
      tick(); check_val("halt_entered", int'(halted), 1);
      run_idle(100, k); check_val("halt_no_rises", k, 0);
      check_val("halt_clk_low", int'(cpu_clk), 0);
      check_val("halt_still_halted", int'(halted), 1);
      button = 1;
`ifdef CLOCK_HALT_RESUME_EN
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (!halted) begin n = i; break; end
      end
      check_val("resume_latency", n, DB + 3);
      button = 0;
      edges_to_rise(20, n); check_val("resume_first_rise", n, 4);
`else
      run_idle(40, k); check_val("halt_press_ignored_rises", k, 0);
      check_val("halt_press_ignored", int'(halted), 1);
      button = 0;
`endif

      // Divider reload below the running count
      rst = 1; tick(); rst = 0;
      div_load = 1; div_value = 24'd10; tick(); div_load = 0;
      edges_to_rise(60, n);
      for (int i = 0; i < 6; i++) tick();
      div_load = 1; div_value = 24'd2; tick(); div_load = 0;
      check_val("reload_still_high", int'(cpu_clk), 1);
      tick(); check_val("reload_phase_end", int'(cpu_clk), 0);
      edges_to_rise(20, n); check_val("reload_next_rise", n, 3);
      edges_to_rise(20, n); check_val("reload_period", n, 6);

      // Reset in the middle of a high phase restores the default divider
      div_load = 1; div_value = 24'd5; tick(); div_load = 0;
      edges_to_rise(40, n);
      tick();
      rst = 1; tick();
      check_val("midhigh_reset_clk", int'(cpu_clk), 0);
      check_val("midhigh_reset_halted", int'(halted), 0);
      rst = 0;
      edges_to_rise(20, n); check_val("midhigh_reset_div", n, 3);

      // Randomized traffic with periodic resets
      r_mode = 0; r_btn = 0; hold = 0;
      for (int seg = 0; seg < 30; seg++) begin
         apply_stimulus(1, r_mode, r_btn, 0, 0, 0);
         for (int c = 0; c < int'($urandom_range(60, 220)); c++) begin
            if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
            if (hold == 0) begin
               r_btn = ~r_btn;
               hold = $urandom_range(1, 24);
            end else begin
               hold--;
            end
            apply_stimulus(0, r_mode, r_btn, ($urandom_range(0, 299) == 0),
                           ($urandom_range(0, 39) == 0), $urandom_range(0, 4));
         end
      end
      apply_stimulus(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_val("rise_queue_drained", rise_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
